// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants and types for the FIFO read-side master
package fifo_rd_pkg;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_rd_buf.sv
// rtl/fifo_rd_buf.sv - small circular output buffer with push/pop, occupancy and head word
module fifo_rd_buf
    import fifo_rd_pkg::*;
#(
    parameter int width = FIFO_WIDTH,
    parameter int depth = 2,
    localparam int pw   = $clog2(depth),
    localparam int ow   = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [ow-1:0]    occ,
    output logic [width-1:0] head
);
    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;

    // Explicit wrap so non-power-of-two depths still work.
    function automatic logic [pw-1:0] next_ptr(input logic [pw-1:0] p);
        return (p == pw'(depth - 1)) ? '0 : p + pw'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < depth; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + ow'(1);
                2'b01:   occ <= occ - ow'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Head comes straight from storage, so it only moves when rd_ptr or the head slot changes.
    assign head = mem[rd_ptr];
endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - read-side master draining a synchronous FIFO onto a valid/ready stream
module fifo_reader
    import fifo_rd_pkg::*;
#(
    parameter int fifo_width = FIFO_WIDTH,
    parameter int buf_depth  = 2,
    parameter int cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [fifo_width-1:0] fifo_data_out,
    output logic                  fifo_read,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [fifo_width-1:0] out_data,
    output logic [cnt_width-1:0]  rd_count,
    output logic                  idle
);
    localparam int ow = $clog2(buf_depth + 1);

    logic          infl;
    logic          pop;
    logic [ow-1:0] occ;

    fifo_rd_buf #(
        .width (fifo_width),
        .depth (buf_depth)
    ) u_buf (
        .clk       (clk),
        .rst_      (rst_),
        .push      (infl),
        .push_data (fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .head      (out_data)
    );

    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready;
    assign idle      = (occ == '0) && !infl;

    // Space check written as occ+infl < depth+pop to stay unsigned; rst_ gates the strobe during reset.
    assign fifo_read = rst_ && en && !fifo_empty &&
                       ((ow + 1)'(occ) + (ow + 1)'(infl) < (ow + 1)'(buf_depth) + (ow + 1)'(pop));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            infl     <= 1'b0;
            rd_count <= '0;
        end else begin
            infl     <= fifo_read;
            rd_count <= rd_count + cnt_width'(pop);
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader against a behavioural FIFO and delivery model
module tb_fifo_reader;
    import fifo_rd_pkg::*;

    localparam int BD = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_;
    logic          en;
    logic          fifo_empty;
    fifo_word_t    fifo_data_out;
    logic          fifo_read;
    logic          out_valid;
    logic          out_ready;
    fifo_word_t    out_data;
    logic [CW-1:0] rd_count;
    logic          idle;

    fifo_word_t    fmem [8];
    logic [2:0]    fwp, frp;
    logic [3:0]    fcnt;
    logic          fifo_rst_;
    logic          wr;
    fifo_word_t    wd;

    fifo_word_t    exp_q [$];
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    fifo_reader #(
        .fifo_width (FIFO_WIDTH),
        .buf_depth  (BD),
        .cnt_width  (CW)
    ) dut (
        .clk           (clk),
        .rst_          (rst_),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read     (fifo_read),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .rd_count      (rd_count),
        .idle          (idle)
    );

    // Behavioural 8-deep synchronous FIFO feeding the reader; data appears the cycle after a read.
    assign fifo_empty = (fcnt == 4'd0);
    always @(posedge clk or negedge fifo_rst_) begin
        if (!fifo_rst_) begin
            fwp <= '0; frp <= '0; fcnt <= '0; fifo_data_out <= '0;
        end else begin
            if (wr) begin
                fmem[fwp] <= wd;
                fwp       <= fwp + 3'd1;
            end
            if (fifo_read && fcnt != 0) begin
                fifo_data_out <= fmem[frp];
                frp           <= frp + 3'd1;
            end
            fcnt <= fcnt + 4'(wr) - 4'(fifo_read && fcnt != 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: words held = reads issued minus words delivered; in-flight = read issued last cycle.
    int         pulled = 0, delivered = 0, exp_cnt = 0, held, pop_i;
    logic       prev_read = 1'b0, prev_stall = 1'b0;
    fifo_word_t prev_data = '0, want;
    always @(negedge clk) begin
        if (!rst_) begin
            pulled = 0; delivered = 0; exp_cnt = 0; prev_read = 1'b0; prev_stall = 1'b0;
        end else begin
            pop_i = (out_valid && out_ready) ? 1 : 0;
            held  = pulled - delivered;
            chk("read_rule", fifo_read, en && !fifo_empty && (held - pop_i) < BD);
            chk("idle_rule", idle, held == 0);
            chk("valid_rule", out_valid, (held - int'(prev_read)) > 0);
            chk("rd_count", rd_count, exp_cnt % (1 << CW));
            if (prev_stall) chk("stall_hold", out_data, prev_data);
            if (pop_i == 1) begin
                chk("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    chk("out_data", out_data, want);
                end
                delivered++;
                exp_cnt++;
            end
            if (fifo_read) pulled++;
            prev_read  = fifo_read;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic push_word(input fifo_word_t d);
        wr = 1'b1; wd = d; exp_q.push_back(d);
        step();
        wr = 1'b0;
    endtask

    task automatic do_reset();
        rst_ = 1'b0; fifo_rst_ = 1'b0; wr = 1'b0; en = 1'b0;
        exp_q.delete();
        cycles(2);
        rst_ = 1'b1; fifo_rst_ = 1'b1;
    endtask

    task automatic count_reads(input int n, output int nr);
        nr = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (fifo_read) nr++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nr, first_rd, last_rd, first_v;
        fifo_word_t first_w;
        rst_ = 1'b0; fifo_rst_ = 1'b0; en = 1'b0; out_ready = 1'b0; wr = 1'b0; wd = '0;
        #2;
        chk("rst_fifo_read", fifo_read, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_idle", idle, 1);
        chk("rst_out_data", out_data, 0);
        do_reset();

        // Streaming from a pre-loaded FIFO
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(8'(8'h11 * (i + 1)));
        en = 1'b1;
        first_rd = -1; last_rd = -1; first_v = -1; nr = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (fifo_read) begin
                nr++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (out_valid && first_v < 0) first_v = c;
        end
        chk("stream_reads", nr, 8);
        chk("stream_first_read", first_rd, 0);
        chk("stream_consecutive", last_rd - first_rd, 7);
        chk("stream_latency", first_v - first_rd, 2);
        chk("stream_count", rd_count, 8);
        chk("stream_idle", idle, 1);
        step();

        // Empty protection, then a single word
        count_reads(20, nr);
        chk("empty_no_read", nr, 0);
        step();
        push_word(8'hA5);
        count_reads(8, nr);
        chk("single_read", nr, 1);
        chk("single_drained", exp_q.size(), 0);
        step();

        // Backpressure
        en = 1'b0; out_ready = 1'b0;
        first_w = 8'($urandom);
        push_word(first_w);
        for (int i = 0; i < 7; i++) push_word(8'($urandom));
        en = 1'b1;
        count_reads(10, nr);
        chk("bp_reads", nr, BD);
        @(negedge clk);
        chk("bp_read_low", fifo_read, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", out_data, first_w);
        step();
        out_ready = 1'b1;
        cycles(14);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_idle", idle, 1);

        // en dropped in the same cycle as a read
        en = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        en = 1'b1;
        @(negedge clk);
        chk("en_read_issued", fifo_read, 1);
        step();
        en = 1'b0;
        count_reads(6, nr);
        chk("en_no_more_reads", nr, 0);
        chk("en_one_delivered", exp_q.size(), 3);
        step();
        en = 1'b1;
        cycles(10);
        chk("en_resume_drained", exp_q.size(), 0);

        // Randomized traffic with backpressure and enable toggling
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            if (($urandom % 2) == 1 && fcnt < 4'd8) begin
                wr = 1'b1; wd = 8'($urandom); exp_q.push_back(wd);
            end else begin
                wr = 1'b0;
            end
            step();
        end
        wr = 1'b0; en = 1'b1; out_ready = 1'b1;
        cycles(20);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_idle", idle, 1);

        // Async reset with a read in flight; only that in-flight word is lost
        en = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'($urandom));
        en = 1'b1;
        @(posedge clk); #2;
        rst_ = 1'b0;
        void'(exp_q.pop_front());
        #1;
        chk("arst_fifo_read", fifo_read, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_rd_count", rd_count, 0);
        chk("arst_idle", idle, 1);
        chk("arst_out_data", out_data, 0);
        cycles(2);
        rst_ = 1'b1; out_ready = 1'b1;
        cycles(10);
        chk("arst_remaining", exp_q.size(), 0);
        chk("arst_idle_after", idle, 1);

        // Counter wrap: 17 words on a 4-bit counter
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'($urandom));
        cycles(10);
        chk("wrap_count", rd_count, 1);
        chk("wrap_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
